// File: rtl/c7b_biu_pkg.sv
// Shared definitions for the BIU read arbiter.
// Contents: FSM state encoding, requester/owner encoding, default line length,
// bus widths and a helper that applies line alignment to a beat address.
package c7b_biu_pkg;

  localparam int unsigned LineBeatsDef = 4;
  localparam int unsigned AddrW        = 29;  // address bits [31:3]
  localparam int unsigned DataW        = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  typedef enum logic {
    OwnIcu = 1'b0,
    OwnDcu = 1'b1
  } owner_e;

  // Line reads start on a line boundary (byte address bits [4:3] cleared);
  // single-beat reads keep the requested beat address.
  function automatic logic [AddrW-1:0] align_addr(input logic [AddrW-1:0] addr,
                                                  input logic             single);
    return single ? addr : {addr[AddrW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/c7bbiu_rr2.sv
// Two-requester round-robin selector.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  synchronous active-low reset (pointer favours requester 0)
//   req_i   request vector, bit 0 = icache, bit 1 = dcache
//   adv_i   grant is being taken this cycle; pointer moves past the winner
//   gnt_o   one-hot grant (all zero when nothing requests)
module c7bbiu_rr2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  // prio_q = 1 means requester 1 wins a tie.
  logic prio_q, prio_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (adv_i && (|req_i)) begin
      // Whoever just won loses the next tie.
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/c7bbiu_rdarb.sv
// Read arbiter between the icache and dcache for a single downstream read port.
// One transaction outstanding at a time: IDLE picks a winner, ADDR presents the
// latched address until the memory accepts it, DATA forwards beats to the owner
// until rlast. Protocol violations set the sticky arb_err flag.
// Ports:
//   clk, resetn                 clock and synchronous active-low reset
//   icu_biu_* / dcu_biu_*       requests (req held until ack, addr [31:3], single)
//   biu_icu_* / biu_dcu_*       ack pulse, beat valid/last/fault and data
//   arb_mem_req/addr/len        downstream address phase (len = beats - 1)
//   mem_arb_ack                 downstream address accepted
//   mem_arb_rvalid/rlast/rerr/rdata  downstream read beats
//   arb_err                     sticky protocol-error flag
module c7bbiu_rdarb
  import c7b_biu_pkg::*;
#(
  parameter int unsigned LINE_BEATS = LineBeatsDef
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             icu_biu_req,
  input  logic [AddrW-1:0] icu_biu_addr,
  input  logic             icu_biu_single,
  output logic             biu_icu_ack,
  output logic             biu_icu_data_valid,
  output logic             biu_icu_data_last,
  output logic             biu_icu_fault,
  output logic [DataW-1:0] biu_icu_data,

  input  logic             dcu_biu_req,
  input  logic [AddrW-1:0] dcu_biu_addr,
  input  logic             dcu_biu_single,
  output logic             biu_dcu_ack,
  output logic             biu_dcu_data_valid,
  output logic             biu_dcu_data_last,
  output logic             biu_dcu_fault,
  output logic [DataW-1:0] biu_dcu_data,

  output logic             arb_mem_req,
  output logic [AddrW-1:0] arb_mem_addr,
  output logic [1:0]       arb_mem_len,
  input  logic             mem_arb_ack,
  input  logic             mem_arb_rvalid,
  input  logic             mem_arb_rlast,
  input  logic             mem_arb_rerr,
  input  logic [DataW-1:0] mem_arb_rdata,

  output logic             arb_err
);

  localparam logic [1:0] LineLen = 2'(LINE_BEATS - 1);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [1:0]       len_q, len_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [1:0]       gnt;
  logic             sel_single;
  logic [AddrW-1:0] sel_addr;

  c7bbiu_rr2 u_rr2 (
    .clk_i  (clk),
    .rst_ni (resetn),
    .req_i  ({dcu_biu_req, icu_biu_req}),
    .adv_i  (state_q == StIdle),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    sel_single = 1'b0;
    sel_addr   = '0;

    if (mem_arb_ack && (state_q != StAddr)) begin
      err_d = 1'b1;
    end
    if (mem_arb_rvalid && (state_q != StData)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          sel_single = gnt[1] ? dcu_biu_single : icu_biu_single;
          sel_addr   = gnt[1] ? dcu_biu_addr   : icu_biu_addr;
          owner_d    = gnt[1] ? OwnDcu : OwnIcu;
          addr_d     = align_addr(sel_addr, sel_single);
          len_d      = sel_single ? 2'd0 : LineLen;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (mem_arb_ack) begin
          cnt_d   = 2'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (mem_arb_rvalid) begin
          // Early rlast and a missing rlast on the expected final beat are
          // both errors; the counter simply wraps while waiting for rlast.
          if (mem_arb_rlast != (cnt_q == len_q)) begin
            err_d = 1'b1;
          end
          cnt_d = cnt_q + 2'd1;
          if (mem_arb_rlast) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= OwnIcu;
      addr_q  <= '0;
      len_q   <= 2'd0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  logic ack_hit, beat_hit, icu_beat, dcu_beat;

  always_comb begin
    ack_hit  = (state_q == StAddr) && mem_arb_ack;
    beat_hit = (state_q == StData) && mem_arb_rvalid;
    icu_beat = beat_hit && (owner_q == OwnIcu);
    dcu_beat = beat_hit && (owner_q == OwnDcu);

    arb_mem_req  = (state_q == StAddr);
    arb_mem_addr = addr_q;
    arb_mem_len  = len_q;

    biu_icu_ack        = ack_hit && (owner_q == OwnIcu);
    biu_icu_data_valid = icu_beat;
    biu_icu_data_last  = icu_beat && mem_arb_rlast;
    biu_icu_fault      = icu_beat && mem_arb_rerr;
    biu_icu_data       = icu_beat ? mem_arb_rdata : '0;

    biu_dcu_ack        = ack_hit && (owner_q == OwnDcu);
    biu_dcu_data_valid = dcu_beat;
    biu_dcu_data_last  = dcu_beat && mem_arb_rlast;
    biu_dcu_fault      = dcu_beat && mem_arb_rerr;
    biu_dcu_data       = dcu_beat ? mem_arb_rdata : '0;

    arb_err = err_q;
  end

endmodule

// File: doc/c7bbiu_rdarb.md
C7BBIU_RDARB -- requirements
Module: c7bbiu_rdarb

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 4, number of 64-bit beats in a line read.
REQ-002 SHALL have ports (name  direction  width  meaning):
 clk  in  1  sole clock, rising edge.
 resetn  in  1  synchronous, active-low reset.
 icu_biu_req  in  1  icache read request, held until ack.
 icu_biu_addr  in  29 [31:3]  icache read address.
 icu_biu_single  in  1  1 = single beat, 0 = line.
 biu_icu_ack / biu_icu_data_valid / biu_icu_data_last / biu_icu_fault  out  1 each  icache response strobes.
 biu_icu_data  out  64  icache read data.
 dcu_biu_req / dcu_biu_addr[31:3] / dcu_biu_single  in  1/29/1  dcache request, same rules as icu.
 biu_dcu_ack / biu_dcu_data_valid / biu_dcu_data_last / biu_dcu_fault  out  1 each  dcache response strobes.
 biu_dcu_data  out  64  dcache read data.
 arb_mem_req  out  1  downstream read address valid.
 arb_mem_addr  out  29 [31:3]  downstream address (line reads aligned to addr[4:3]=0).
 arb_mem_len  out  2  beats minus one (0 single, LINE_BEATS-1 line).
 mem_arb_ack  in  1  downstream address accepted.
 mem_arb_rvalid / mem_arb_rlast / mem_arb_rerr  in  1 each  read beat valid, last beat, error.
 mem_arb_rdata  in  64  read beat data.
 arb_err  out  1  sticky protocol-error flag.

Function
REQ-003 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; only one outstanding transaction.
REQ-004 IDLE: any req high SHALL select a winner, latch owner/addr/len, enter ADDR next cycle; arb_mem_req first high the cycle after req sampled.
REQ-005 Both req high in IDLE SHALL grant the requester not granted last (round-robin); pointer resets to favour icu.
REQ-006 ADDR: arb_mem_req, arb_mem_addr, arb_mem_len SHALL be stable from registers; on mem_arb_ack, owner's ack SHALL pulse high that same cycle only, FSM to DATA.
REQ-007 Line requests SHALL force arb_mem_addr[4:3]=2'b00; single requests pass address unchanged.
REQ-008 DATA: each mem_arb_rvalid SHALL drive owner's data_valid, data, data_last (=mem_arb_rlast), fault (=mem_arb_rerr) combinationally, zero latency; non-owner strobes stay 0, non-owner data 0.
REQ-009 2-bit beat counter SHALL clear at ack, increment per rvalid; FSM SHALL return to IDLE on rvalid&rlast.
REQ-010 rlast on beat != len, or rvalid in IDLE/ADDR, SHALL set arb_err; beat still forwarded in DATA, dropped otherwise; FSM still exits on rlast.
REQ-011 Counter reaching len without rlast SHALL set arb_err and continue waiting for rlast (wraps modulo 4).
REQ-012 New winner SHALL be selected in the IDLE cycle after rlast (no back-to-back grant in the rlast cycle); round-robin pointer updates at grant.
REQ-013 Requester dropping req before ack is illegal; arbiter SHALL ignore it and complete the latched transaction.
REQ-014 mem_arb_ack outside ADDR SHALL be ignored and set arb_err.

Reset
REQ-015 resetn low at a clock edge SHALL force IDLE, counter 0, pointer = icu-first, arb_err 0, all outputs 0, regardless of state; in-flight beats after reset are treated per REQ-010.

Structure
REQ-016 FSM state encoding, owner encoding (ICU=0, DCU=1) and LINE_BEATS default SHALL live in shared package c7b_biu_pkg.
REQ-017 Round-robin selection SHALL be a sub-module c7bbiu_rr2 (2 requesters, pointer register, grant one-hot); rest flat.

Verification
REQ-018 icu line req 0x0000_1008>>3 alone; mem ack 2 cycles later, 4 beats -> arb_mem_addr=0x0000_1000>>3, len=3, one biu_icu_ack pulse, 4 icu data_valid, last on beat 4, no dcu strobes.
REQ-019 icu and dcu req same cycle from reset -> icu granted first; dcu granted in IDLE cycle after icu rlast; third simultaneous pair -> icu.
REQ-020 dcu single req addr 0x0000_2004>>3 -> addr unchanged, len=0, one beat with data_last=1, FSM IDLE next cycle.
REQ-021 line read with mem_arb_rerr on beat 2 -> biu_icu_fault high exactly on beat 2, arb_err stays 0.
REQ-022 rlast on beat 3 of line read -> arb_err=1, return to IDLE; stray rvalid in IDLE -> arb_err stays 1, no requester strobes.
REQ-023 resetn low during DATA beat 2 -> next cycle all outputs 0, IDLE; subsequent icu req served normally.
